rom_arbiter: RTL and testbench

- Shares one synchronous-read, single-port program ROM between two requesters.
- Port 0 is the CPU instruction fetch; port 1 is the data/debug read path.
- The ROM has a 15-bit word address and 16-bit data, registers its read at the clock edge, and forces its output to 0 while enable is low.
- This block arbitrates requesters round-robin, sequences the ROM enable/address timing, and returns captured read data with a one-cycle valid pulse per requester.

---
 rtl/rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_rom_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous-read, single-port program ROM between
// two requesters. Port 0 is the CPU instruction fetch and port 1 is the
// data/debug read path. Requesters are served round-robin, one read every
// two cycles under continuous demand.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req0/addr0          port 0 request (level) and word address
//   gnt0                one-cycle pulse: port 0 accepted, address latched
//   rdata0/rvalid0      port 0 read data (held) and one-cycle update pulse
//   req1..rvalid1       same for port 1
//   rom_enable/rom_addr registered ROM enable and address
//   rom_data            ROM read data (registered inside the ROM)
module rom_arbiter #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              rom_enable_q, rom_enable_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic any_req;
  logic winner;
  logic accept;

  // Sole requester wins; on a tie the port that was not served last wins.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last_q : req1;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    rom_enable_d = rom_enable_q;
    rom_addr_d   = rom_addr_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        accept = any_req;
      end
      ISSUE: begin
        // ROM registers its word on this edge; data is valid in CAPTURE.
        state_d      = CAPTURE;
        rom_enable_d = 1'b1;
      end
      CAPTURE: begin
        if (owner_q) begin
          rdata1_d  = rom_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = rom_data;
          rvalid0_d = 1'b1;
        end
        // Back-to-back accept keeps the ROM busy with no idle cycle.
        if (any_req) begin
          accept = 1'b1;
        end else begin
          state_d      = IDLE;
          rom_enable_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        rom_enable_d = 1'b0;
      end
    endcase

    if (accept) begin
      state_d      = ISSUE;
      rom_enable_d = 1'b1;
      rom_addr_d   = winner ? addr1 : addr0;
      owner_d      = winner;
      last_d       = winner;
      gnt0_d       = ~winner;
      gnt1_d       = winner;
    end
  end

  // State and output registers; reset discards any in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rom_enable_q <= 1'b0;
      rom_addr_q   <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rom_enable_q <= rom_enable_d;
      rom_addr_q   <= rom_addr_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign rom_enable = rom_enable_q;
  assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed testbench for rom_arbiter with a behavioural synchronous ROM.
module tb_rom_arbiter;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              rom_enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] rom_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .addr0     (addr0),
    .gnt0      (gnt0),
    .rdata0    (rdata0),
    .rvalid0   (rvalid0),
    .req1      (req1),
    .addr1     (addr1),
    .gnt1      (gnt1),
    .rdata1    (rdata1),
    .rvalid1   (rvalid1),
    .rom_enable(rom_enable),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  // ROM contents; anything not listed reads as zero.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      15'h0000: return 16'h5341;
      15'h0001: return 16'h4D52;
      15'h004B: return 16'h00E8;
      15'h0002: return 16'h1002;
      15'h0003: return 16'h2003;
      15'h0004: return 16'h1004;
      15'h0005: return 16'h2005;
      15'h0006: return 16'h1006;
      15'h0007: return 16'h2007;
      15'h0008: return 16'h1008;
      15'h0009: return 16'h2009;
      default:  return 16'h0000;
    endcase
  endfunction

  // Synchronous read, output forced to zero while disabled.
  always @(posedge clk) begin
    if (rom_enable) rom_q <= rom_word(rom_addr);
  end
  assign rom_data = rom_enable ? rom_q : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int                p;
  int                idx;
  logic [ADDR_W-1:0] exp_addr;

  initial begin
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = '0;
    addr1 = '0;
    #12;
    // Reset state
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    chk("rst_en", 32'(rom_enable), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;

    // Single port 0 read of word 1
    req0 = 1'b1; addr0 = 15'h0001;
    step();
    chk("t1_gnt0", 32'(gnt0), 32'd1);
    chk("t1_gnt1", 32'(gnt1), 32'd0);
    chk("t1_en", 32'(rom_enable), 32'd1);
    chk("t1_addr", 32'(rom_addr), 32'h1);
    req0 = 1'b0;
    step();
    chk("t1_gnt0_off", 32'(gnt0), 32'd0);
    chk("t1_rvalid0_early", 32'(rvalid0), 32'd0);
    step();
    chk("t1_rvalid0", 32'(rvalid0), 32'd1);
    chk("t1_rdata0", 32'(rdata0), 32'h4D52);
    chk("t1_rvalid1", 32'(rvalid1), 32'd0);
    chk("t1_gnt1_never", 32'(gnt1), 32'd0);
    step();
    chk("t1_rvalid0_off", 32'(rvalid0), 32'd0);
    chk("t1_en_off", 32'(rom_enable), 32'd0);
    chk("t1_rdata0_hold", 32'(rdata0), 32'h4D52);

    // Simultaneous requests after reset: port 0 first, port 1 at CAPTURE
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    req0 = 1'b1; addr0 = 15'h0000;
    req1 = 1'b1; addr1 = 15'h004B;
    step();
    chk("t2_gnt0", 32'(gnt0), 32'd1);
    chk("t2_gnt1", 32'(gnt1), 32'd0);
    chk("t2_addr0", 32'(rom_addr), 32'h0);
    req0 = 1'b0;
    step();
    chk("t2_gnt0_off", 32'(gnt0), 32'd0);
    step();
    chk("t2_rvalid0", 32'(rvalid0), 32'd1);
    chk("t2_rdata0", 32'(rdata0), 32'h5341);
    chk("t2_gnt1_b2b", 32'(gnt1), 32'd1);
    chk("t2_addr1", 32'(rom_addr), 32'h4B);
    chk("t2_en_b2b", 32'(rom_enable), 32'd1);
    req1 = 1'b0;
    step();
    chk("t2_gnt1_off", 32'(gnt1), 32'd0);
    chk("t2_rvalid0_off", 32'(rvalid0), 32'd0);
    step();
    chk("t2_rvalid1", 32'(rvalid1), 32'd1);
    chk("t2_rdata1", 32'(rdata1), 32'h00E8);
    chk("t2_rdata0_hold", 32'(rdata0), 32'h5341);
    step();
    chk("t2_rvalid1_off", 32'(rvalid1), 32'd0);
    chk("t2_en_off", 32'(rom_enable), 32'd0);

    // Continuous contention: 8 reads, alternating grants, no idle cycles
    addr0 = 15'h0002; addr1 = 15'h0003;
    req0 = 1'b1; req1 = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      p   = k % 2;
      idx = k / 2;
      exp_addr = (p == 1) ? 15'(3 + 2 * idx) : 15'(2 + 2 * idx);
      chk($sformatf("t3_gnt0_%0d", k), 32'(gnt0), (p == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_gnt1_%0d", k), 32'(gnt1), (p == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t3_addr_%0d", k), 32'(rom_addr), 32'(exp_addr));
      // The granted requester moves to its next address after seeing gnt.
      if (p == 0) addr0 = 15'(2 + 2 * (idx + 1));
      else        addr1 = 15'(3 + 2 * (idx + 1));
      step();
      chk($sformatf("t3_en_issue_%0d", k), 32'(rom_enable), 32'd1);
      if (k == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();
      chk($sformatf("t3_rvalid0_%0d", k), 32'(rvalid0), (p == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_rvalid1_%0d", k), 32'(rvalid1), (p == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t3_rdata_%0d", k), (p == 0) ? 32'(rdata0) : 32'(rdata1),
          32'(rom_word(exp_addr)));
    end
    chk("t3_en_end", 32'(rom_enable), 32'd0);

    // Unmapped address reads as zero
    req0 = 1'b1; addr0 = 15'h0100;
    step();
    chk("t4_gnt0", 32'(gnt0), 32'd1);
    chk("t4_addr", 32'(rom_addr), 32'h100);
    req0 = 1'b0;
    step();
    step();
    chk("t4_rvalid0", 32'(rvalid0), 32'd1);
    chk("t4_rdata0", 32'(rdata0), 32'h0);
    step();

    // Port 1 read, then port 0 read: port 1 data retained
    req1 = 1'b1; addr1 = 15'h004B;
    step();
    chk("t6_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step();
    step();
    chk("t6_rvalid1", 32'(rvalid1), 32'd1);
    chk("t6_rdata1", 32'(rdata1), 32'h00E8);
    step();
    req0 = 1'b1; addr0 = 15'h0001;
    step();
    chk("t6_gnt0", 32'(gnt0), 32'd1);
    chk("t6_gnt1_quiet", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    step();
    chk("t6_rvalid1_quiet_a", 32'(rvalid1), 32'd0);
    step();
    chk("t6_rvalid0", 32'(rvalid0), 32'd1);
    chk("t6_rdata0", 32'(rdata0), 32'h4D52);
    chk("t6_rvalid1_quiet_b", 32'(rvalid1), 32'd0);
    chk("t6_rdata1_hold", 32'(rdata1), 32'h00E8);
    step();

    // Asynchronous reset during ISSUE discards the read
    req0 = 1'b1; addr0 = 15'h0002;
    step();
    chk("t5_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_async_gnt0", 32'(gnt0), 32'd0);
    chk("t5_async_en", 32'(rom_enable), 32'd0);
    chk("t5_async_addr", 32'(rom_addr), 32'd0);
    chk("t5_async_rdata0", 32'(rdata0), 32'd0);
    chk("t5_async_rdata1", 32'(rdata1), 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_no_rvalid0_%0d", k), 32'(rvalid0), 32'd0);
      chk($sformatf("t5_idle_en_%0d", k), 32'(rom_enable), 32'd0);
    end
    req0 = 1'b1; addr0 = 15'h0004;
    req1 = 1'b1; addr1 = 15'h0005;
    step();
    chk("t5_tie_gnt0", 32'(gnt0), 32'd1);
    chk("t5_tie_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    step();
    step();
    chk("t5_rvalid0", 32'(rvalid0), 32'd1);
    chk("t5_rdata0", 32'(rdata0), 32'h1004);
    chk("t5_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step();
    step();
    chk("t5_rvalid1", 32'(rvalid1), 32'd1);
    chk("t5_rdata1", 32'(rdata1), 32'h2005);
    step();
    chk("t5_en_end", 32'(rom_enable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
